// File: rtl/latch_bank_shadow_commit.sv
// Shadowed value bank: word-serial host loads, atomic all-channel commit on sync.
// Define COMMIT_TIMEOUT_EN to force a commit after TIMEOUT_CYC cycles armed.
module latch_bank_shadow_commit #(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 48,
  parameter int BUS_W       = 16,
  parameter int ADDR_W      = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Wr_Valid,
  output logic                     Wr_Ready,
  input  logic                     Wr_First,
  input  logic [ADDR_W-1:0]        Wr_Addr,
  input  logic [BUS_W-1:0]         Wr_Data,
  input  logic                     Commit_Req,
  input  logic                     Commit_Sync,
  output logic                     Commit_Done,
  output logic [NUM_CH-1:0]        Pending_Mask,
  output logic [NUM_CH*DATA_W-1:0] Active_Bus,
  input  logic                     Err_Clr,
  output logic                     Err_Flag
);

  localparam int BEATS = (DATA_W + BUS_W - 1) / BUS_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = BEATS * BUS_W;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  if (TIMEOUT_CYC < 1 || (2 ** ADDR_W) < NUM_CH) begin : g_bad_cfg
    $error("latch_bank_shadow_commit: bad parameters");
  end

  typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [AW-1:0]       asm_q, asm_d;
  logic                cmt_q, cmt_d;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   shadow_q [NUM_CH];
  logic [DATA_W-1:0]   shadow_d [NUM_CH];
  logic [DATA_W-1:0]   active_q [NUM_CH];
  logic [DATA_W-1:0]   active_d [NUM_CH];

  logic              acc;
  logic              start;
  logic              cmt_any;
  logic              err_set;
  logic              wr_done;
  logic [ADDR_W-1:0] wr_addr;
  logic              fire;

`ifdef COMMIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign Wr_Ready = (state_q != ARMED);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    asm_d    = asm_q;
    cmt_d    = cmt_q;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    active_d = active_q;
    done_d   = 1'b0;
    err_set  = 1'b0;
    wr_done  = 1'b0;
    wr_addr  = addr_q;
    fire     = 1'b0;
    acc      = Wr_Valid & Wr_Ready;
    start    = acc & Wr_First;
    cmt_any  = cmt_q | Commit_Req;
`ifdef COMMIT_TIMEOUT_EN
    tmo_d    = '0;
`endif

    unique case (state_q)
      IDLE: begin
        if (acc && !Wr_First) err_set = 1'b1;
        if (Commit_Req) state_d = ARMED;
      end
      LOAD: begin
        cmt_d = cmt_any;
        if (acc && Wr_First) begin
          err_set = 1'b1;
        end else if (acc && Wr_Addr != addr_q) begin
          err_set = 1'b1;
          beat_d  = '0;
          asm_d   = '0;
          cmt_d   = 1'b0;
          state_d = cmt_any ? ARMED : IDLE;
        end else if (acc) begin
          asm_d[int'(beat_q)*BUS_W +: BUS_W] = Wr_Data;
          beat_d = beat_q + BW'(1);
          if (beat_q == LAST) begin
            wr_done = 1'b1;
            beat_d  = '0;
            cmt_d   = 1'b0;
            state_d = cmt_any ? ARMED : IDLE;
          end
        end
      end
      ARMED: begin
        fire = Commit_Sync;
`ifdef COMMIT_TIMEOUT_EN
        tmo_d = tmo_q + TW'(1);
        if (!Commit_Sync && tmo_q == TMO_LAST) begin
          fire    = 1'b1;
          err_set = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // A first beat (re)starts assembly from IDLE or mid-sequence
    if (start) begin
      asm_d              = '0;
      asm_d[BUS_W-1:0]   = Wr_Data;
      addr_d             = Wr_Addr;
      wr_addr            = Wr_Addr;
      beat_d             = BW'(1);
      cmt_d              = cmt_any;
      state_d            = LOAD;
      if (BEATS == 1) begin
        wr_done = 1'b1;
        beat_d  = '0;
        cmt_d   = 1'b0;
        state_d = cmt_any ? ARMED : IDLE;
      end
    end

    if (wr_done) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_addr == ADDR_W'(c)) begin
          shadow_d[c] = asm_d[DATA_W-1:0];
          pend_d[c]   = 1'b1;
        end
      end
    end

    if (fire) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (pend_q[c]) active_d[c] = shadow_q[c];
      end
      pend_d  = '0;
      done_d  = 1'b1;
      state_d = IDLE;
    end

    err_d = Err_Clr ? 1'b0 : (err_q | err_set);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      beat_q   <= '0;
      asm_q    <= '0;
      cmt_q    <= 1'b0;
      pend_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
`ifdef COMMIT_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      asm_q    <= asm_d;
      cmt_q    <= cmt_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
`ifdef COMMIT_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign Active_Bus[c*DATA_W +: DATA_W] = active_q[c];
  end

  assign Pending_Mask = pend_q;
  assign Commit_Done  = done_q;
  assign Err_Flag     = err_q;

endmodule

// File: tb/tb_latch_bank_shadow_commit.sv
// Directed bench for latch_bank_shadow_commit (8 ch x 48 b, 16-b bus).
// Timeout section runs only when COMMIT_TIMEOUT_EN is defined.
module tb_latch_bank_shadow_commit;

  localparam int NC = 8;
  localparam int DW = 48;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          Wr_Valid = 1'b0;
  logic          Wr_Ready;
  logic          Wr_First = 1'b0;
  logic [2:0]    Wr_Addr = '0;
  logic [15:0]   Wr_Data = '0;
  logic          Commit_Req = 1'b0;
  logic          Commit_Sync = 1'b0;
  logic          Commit_Done;
  logic [NC-1:0] Pending_Mask;
  logic [NC*DW-1:0] Active_Bus;
  logic          Err_Clr = 1'b0;
  logic          Err_Flag;

  int checks = 0;
  int errors = 0;
  int n;
  logic [NC*DW-1:0] exp_act = '0;

  latch_bank_shadow_commit #(
    .NUM_CH(NC), .DATA_W(DW), .BUS_W(16),
    .ADDR_W(3), .TIMEOUT_CYC(16)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready),
    .Wr_First(Wr_First), .Wr_Addr(Wr_Addr),
    .Wr_Data(Wr_Data), .Commit_Req(Commit_Req),
    .Commit_Sync(Commit_Sync), .Commit_Done(Commit_Done),
    .Pending_Mask(Pending_Mask), .Active_Bus(Active_Bus),
    .Err_Clr(Err_Clr), .Err_Flag(Err_Flag)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [383:0] obs,
                     input logic [383:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic f, input logic [2:0] a,
                      input logic [15:0] d);
    Wr_Valid = 1'b1;
    Wr_First = f;
    Wr_Addr  = a;
    Wr_Data  = d;
    step();
    Wr_Valid = 1'b0;
    Wr_First = 1'b0;
  endtask

  task automatic req();
    Commit_Req = 1'b1;
    step();
    Commit_Req = 1'b0;
  endtask

  task automatic sync();
    Commit_Sync = 1'b1;
    step();
    Commit_Sync = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_act", Active_Bus, '0);
    chk("rst_pend", Pending_Mask, '0);
    chk("rst_done", Commit_Done, 1'b0);
    chk("rst_err", Err_Flag, 1'b0);
    @(negedge Clock);
    Reset = 1'b1;
    step();
    chk("rst_ready", Wr_Ready, 1'b1);

    // basic load + commit on ch2
    beat(1'b1, 3'd2, 16'h1111);
    beat(1'b0, 3'd2, 16'h2222);
    chk("b_pend_mid", Pending_Mask, 8'h00);
    beat(1'b0, 3'd2, 16'h3333);
    chk("b_pend", Pending_Mask, 8'h04);
    chk("b_act_pre", Active_Bus, '0);
    req();
    chk("b_ready_arm", Wr_Ready, 1'b0);
    beat(1'b1, 3'd4, 16'h9999);
    chk("b_ign_pend", Pending_Mask, 8'h04);
    chk("b_ign_err", Err_Flag, 1'b0);
    step();
    step();
    step();
    chk("b_act_wait", Active_Bus, '0);
    chk("b_done_wait", Commit_Done, 1'b0);
    sync();
    exp_act[2*DW +: DW] = 48'h3333_2222_1111;
    chk("b_act", Active_Bus, exp_act);
    chk("b_done", Commit_Done, 1'b1);
    chk("b_pend_clr", Pending_Mask, 8'h00);
    step();
    chk("b_done_1cyc", Commit_Done, 1'b0);
    chk("b_ready_idle", Wr_Ready, 1'b1);

    // atomic ch0 + ch7
    beat(1'b1, 3'd0, 16'hCCCC);
    beat(1'b0, 3'd0, 16'hBBBB);
    beat(1'b0, 3'd0, 16'hAAAA);
    beat(1'b1, 3'd7, 16'h0001);
    beat(1'b0, 3'd7, 16'h0000);
    beat(1'b0, 3'd7, 16'h0000);
    chk("m_pend", Pending_Mask, 8'h81);
    req();
    chk("m_act_pre", Active_Bus, exp_act);
    sync();
    exp_act[0*DW +: DW] = 48'hAAAA_BBBB_CCCC;
    exp_act[7*DW +: DW] = 48'h0000_0000_0001;
    chk("m_act", Active_Bus, exp_act);
    chk("m_done", Commit_Done, 1'b1);

    // protocol errors
    beat(1'b0, 3'd3, 16'h5555);
    chk("e_idle_err", Err_Flag, 1'b1);
    chk("e_idle_pend", Pending_Mask, 8'h00);
    Err_Clr = 1'b1;
    step();
    Err_Clr = 1'b0;
    chk("e_clr", Err_Flag, 1'b0);
    beat(1'b1, 3'd3, 16'h1111);
    chk("e_noerr", Err_Flag, 1'b0);
    beat(1'b0, 3'd4, 16'h2222);
    chk("e_sw_err", Err_Flag, 1'b1);
    chk("e_sw_pend", Pending_Mask, 8'h00);
    chk("e_sw_ready", Wr_Ready, 1'b1);
    Err_Clr = 1'b1;
    beat(1'b0, 3'd1, 16'h7777);
    Err_Clr = 1'b0;
    chk("e_clr_prio", Err_Flag, 1'b0);
    req();
    sync();
    chk("e_empty_done", Commit_Done, 1'b1);
    chk("e_empty_act", Active_Bus, exp_act);

    // restart with Wr_First mid-sequence
    beat(1'b1, 3'd6, 16'h0001);
    beat(1'b1, 3'd6, 16'hAAAA);
    chk("r_err", Err_Flag, 1'b1);
    beat(1'b0, 3'd6, 16'hBBBB);
    beat(1'b0, 3'd6, 16'hCCCC);
    chk("r_pend", Pending_Mask, 8'h40);
    Err_Clr = 1'b1;
    step();
    Err_Clr = 1'b0;

    // overwrite ch3, then commit latched during ch5 load
    beat(1'b1, 3'd3, 16'h3333);
    beat(1'b0, 3'd3, 16'h2222);
    beat(1'b0, 3'd3, 16'h1111);
    beat(1'b1, 3'd3, 16'h6666);
    beat(1'b0, 3'd3, 16'h5555);
    beat(1'b0, 3'd3, 16'h4444);
    beat(1'b1, 3'd5, 16'h0505);
    beat(1'b0, 3'd5, 16'h0606);
    req();
    chk("l_ready_load", Wr_Ready, 1'b1);
    beat(1'b0, 3'd5, 16'h0707);
    chk("l_ready_arm", Wr_Ready, 1'b0);
    chk("l_pend", Pending_Mask, 8'h68);
    step();
    step();
    chk("l_ready_hold", Wr_Ready, 1'b0);
    chk("l_act_pre", Active_Bus, exp_act);
    sync();
    exp_act[3*DW +: DW] = 48'h4444_5555_6666;
    exp_act[5*DW +: DW] = 48'h0707_0606_0505;
    exp_act[6*DW +: DW] = 48'hCCCC_BBBB_AAAA;
    chk("l_act", Active_Bus, exp_act);
    chk("l_done", Commit_Done, 1'b1);
    chk("l_pend_clr", Pending_Mask, 8'h00);
    chk("l_err", Err_Flag, 1'b0);

    // stray sync, then reset while armed
    beat(1'b1, 3'd1, 16'h0001);
    beat(1'b0, 3'd1, 16'hBEEF);
    beat(1'b0, 3'd1, 16'hDEAD);
    sync();
    chk("s_done", Commit_Done, 1'b0);
    chk("s_act", Active_Bus, exp_act);
    chk("s_pend", Pending_Mask, 8'h02);
    req();
    chk("x_ready_arm", Wr_Ready, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    exp_act = '0;
    chk("x_act_async", Active_Bus, exp_act);
    chk("x_pend_async", Pending_Mask, 8'h00);
    @(negedge Clock);
    Reset = 1'b1;
    step();
    chk("x_ready", Wr_Ready, 1'b1);
    chk("x_pend", Pending_Mask, 8'h00);
    chk("x_act", Active_Bus, exp_act);

`ifdef COMMIT_TIMEOUT_EN
    beat(1'b1, 3'd6, 16'h0006);
    beat(1'b0, 3'd6, 16'h0000);
    beat(1'b0, 3'd6, 16'h0000);
    req();
    n = 0;
    while (!Commit_Done && n < 40) begin
      step();
      n++;
    end
    exp_act[6*DW +: DW] = 48'h6;
    chk("t_cycles", n, 16);
    chk("t_err", Err_Flag, 1'b1);
    chk("t_act", Active_Bus, exp_act);
    chk("t_pend", Pending_Mask, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
